// File: rtl/period_counter_pkg.sv
// Shared types and constants for the period counter time base.
package period_counter_pkg;

  localparam int DEFAULT_WIDTH  = 16;
  localparam int DEFAULT_CWIDTH = 16;

  // A num_periods value of CONTINUOUS means "run until stopped".
  localparam int CONTINUOUS = 0;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// Turns an asynchronous level into a single-cycle pulse in the clock domain.
module sync_edge_detect (
  input  logic clock,
  input  logic reset_n,
  input  logic async_i,
  output logic pulse_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic pulse_q;
  logic pulse_d;

  assign pulse_d = sync2_q & ~prev_q;

  // Synchronize the async input, remember its last value and register the edge pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= async_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/period_counter.sv
// Programmable period counter producing the time base for the comparator stage.
// Runs a burst of num_periods periods (0 = continuous) of period+1 cycles each,
// with a wrap strobe per period and a done strobe on natural burst completion.
// Optional feature macro PERIOD_COUNTER_EXT_TRIG_EN adds an asynchronous ext_trig
// launch input that is synchronized, edge-detected and ORed with start.
module period_counter
  import period_counter_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int CWIDTH = DEFAULT_CWIDTH
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
`ifdef PERIOD_COUNTER_EXT_TRIG_EN
  input  logic              ext_trig,
`endif
  input  logic [WIDTH-1:0]  period,
  input  logic [CWIDTH-1:0] num_periods,
  output logic [WIDTH-1:0]  count,
  output logic              running,
  output logic              wrap,
  output logic              done,
  output logic [CWIDTH-1:0] periods_done
);

  logic              launchReq;

`ifdef PERIOD_COUNTER_EXT_TRIG_EN
  logic              trigPulse;

  sync_edge_detect uSyncEdge (
    .clock   (clock),
    .reset_n (reset_n),
    .async_i (ext_trig),
    .pulse_o (trigPulse)
  );

  assign launchReq = start | trigPulse;
`else
  assign launchReq = start;
`endif

  logic              startIn_q;
  logic              stopIn_q;
  logic [WIDTH-1:0]  periodIn_q;
  logic [CWIDTH-1:0] numIn_q;

  state_t            state_q,       state_d;
  logic [WIDTH-1:0]  count_q,       count_d;
  logic              wrap_q,        wrap_d;
  logic              done_q,        done_d;
  logic [CWIDTH-1:0] periodsDone_q, periodsDone_d;
  logic [WIDTH-1:0]  period_q,      period_d;
  logic [CWIDTH-1:0] num_q,         num_d;

  logic [WIDTH-1:0]  countInc;
  logic              isWrap;
  logic              isLast;
  logic              launch;

  assign countInc = count_q + WIDTH'(1);
  assign isWrap   = (count_q == period_q);
  assign isLast   = (num_q != CWIDTH'(CONTINUOUS)) &&
                    (periodsDone_q == (num_q - CWIDTH'(1)));
  assign launch   = startIn_q & ~stopIn_q;

  // Register the launch controls and settings so a start seen at one edge acts at the next.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      startIn_q  <= 1'b0;
      stopIn_q   <= 1'b0;
      periodIn_q <= '0;
      numIn_q    <= '0;
    end else begin
      startIn_q  <= launchReq;
      stopIn_q   <= stop;
      periodIn_q <= period;
      numIn_q    <= num_periods;
    end
  end

  // Next-state logic: launch from IDLE, count and wrap in RUN, finish on stop or last period.
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    wrap_d        = 1'b0;
    done_d        = 1'b0;
    periodsDone_d = periodsDone_q;
    period_d      = period_q;
    num_d         = num_q;

    case (state_q)
      IDLE: begin
        count_d = '0;
        if (launch) begin
          state_d       = RUN;
          period_d      = periodIn_q;
          num_d         = numIn_q;
          periodsDone_d = '0;
          wrap_d        = (periodIn_q == '0);
        end
      end

      RUN: begin
        if (stop) begin
          state_d = IDLE;
          count_d = '0;
        end else if (isWrap) begin
          count_d = '0;
          if (periodsDone_q != '1) begin
            periodsDone_d = periodsDone_q + CWIDTH'(1);
          end
          if (isLast) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            wrap_d = (period_q == '0);
          end
        end else begin
          count_d = countInc;
          wrap_d  = (countInc == period_q);
        end
      end

      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      count_q       <= '0;
      wrap_q        <= 1'b0;
      done_q        <= 1'b0;
      periodsDone_q <= '0;
      period_q      <= '0;
      num_q         <= '0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      wrap_q        <= wrap_d;
      done_q        <= done_d;
      periodsDone_q <= periodsDone_d;
      period_q      <= period_d;
      num_q         <= num_d;
    end
  end

  assign count        = count_q;
  assign running      = (state_q == RUN);
  assign wrap         = wrap_q;
  assign done         = done_q;
  assign periods_done = periodsDone_q;

endmodule

// File: tb/tb_period_counter.sv
// Directed self-checking bench for period_counter.
// The ext_trig section is built only when PERIOD_COUNTER_EXT_TRIG_EN is defined.
module tb_period_counter;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic        stop;
  logic        extTrig;
  logic [15:0] period;
  logic [15:0] numPeriods;
  logic [15:0] count;
  logic        running;
  logic        wrap;
  logic        done;
  logic [15:0] periodsDone;

  int checkCount = 0;
  int passCount  = 0;

  period_counter #(.WIDTH(16), .CWIDTH(16)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start),
    .stop         (stop),
`ifdef PERIOD_COUNTER_EXT_TRIG_EN
    .ext_trig     (extTrig),
`endif
    .period       (period),
    .num_periods  (numPeriods),
    .count        (count),
    .running      (running),
    .wrap         (wrap),
    .done         (done),
    .periods_done (periodsDone)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Pulse start for one cycle with the given settings and land on the first RUN cycle.
  task automatic applyStimulus(input logic [15:0] p, input logic [15:0] n);
    period     = p;
    numPeriods = n;
    start      = 1'b1;
    @(negedge clock);
    start = 1'b0;
    checkOutput("launchStillIdle", 32'(running), 32'd0);
    @(negedge clock);
    checkOutput("launchRunning", 32'(running), 32'd1);
    checkOutput("launchCount", 32'(count), 32'd0);
  endtask

  // Safety net so the run can never hang.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main directed sequence.
  initial begin
    int wrapsSeen;
    int doneSeen;
    int lowCnt;
    int highCnt;
    bit found;

    reset_n    = 1'b0;
    start      = 1'b0;
    stop       = 1'b0;
    extTrig    = 1'b0;
    period     = '0;
    numPeriods = '0;

    repeat (2) @(negedge clock);
    checkOutput("rstCount", 32'(count), 32'd0);
    checkOutput("rstRunning", 32'(running), 32'd0);
    checkOutput("rstWrap", 32'(wrap), 32'd0);
    checkOutput("rstDone", 32'(done), 32'd0);
    checkOutput("rstPeriodsDone", 32'(periodsDone), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    checkOutput("idleRunning", 32'(running), 32'd0);

    // Burst of three periods of five cycles.
    applyStimulus(16'd4, 16'd3);
    for (int i = 0; i < 15; i++) begin
      checkOutput("burstCount", 32'(count), 32'(i % 5));
      checkOutput("burstWrap", 32'(wrap), (i % 5 == 4) ? 32'd1 : 32'd0);
      checkOutput("burstPeriodsDone", 32'(periodsDone), 32'(i / 5));
      checkOutput("burstRunning", 32'(running), 32'd1);
      checkOutput("burstNoDone", 32'(done), 32'd0);
      @(negedge clock);
    end
    checkOutput("burstDone", 32'(done), 32'd1);
    checkOutput("burstIdle", 32'(running), 32'd0);
    checkOutput("burstIdleCount", 32'(count), 32'd0);
    checkOutput("burstPeriodsFinal", 32'(periodsDone), 32'd3);
    @(negedge clock);
    checkOutput("burstDoneOneCycle", 32'(done), 32'd0);
    checkOutput("burstPeriodsHold", 32'(periodsDone), 32'd3);

    // Continuous run of period 9; the period input changes mid-run and must be ignored.
    applyStimulus(16'd9, 16'd0);
    wrapsSeen = 0;
    doneSeen  = 0;
    for (int i = 0; i < 500; i++) begin
      if (i == 100) period = 16'd20;
      checkOutput("contCount", 32'(count), 32'(i % 10));
      checkOutput("contWrap", 32'(wrap), (i % 10 == 9) ? 32'd1 : 32'd0);
      if (wrap) wrapsSeen++;
      if (done) doneSeen++;
      @(negedge clock);
    end
    checkOutput("contWraps", 32'(wrapsSeen), 32'd50);
    checkOutput("contNoDone", 32'(doneSeen), 32'd0);
    checkOutput("contPeriodsDone", 32'(periodsDone), 32'd50);
    checkOutput("contStillRunning", 32'(running), 32'd1);
    stop = 1'b1;
    @(negedge clock);
    stop = 1'b0;
    checkOutput("stopIdle", 32'(running), 32'd0);
    checkOutput("stopCount", 32'(count), 32'd0);
    checkOutput("stopNoDone", 32'(done), 32'd0);
    checkOutput("stopPeriodsHold", 32'(periodsDone), 32'd50);
    @(negedge clock);
    checkOutput("stopNoDoneLater", 32'(done), 32'd0);

    // Zero period: wrap every cycle, five-cycle burst.
    applyStimulus(16'd0, 16'd5);
    for (int i = 0; i < 5; i++) begin
      checkOutput("zeroWrap", 32'(wrap), 32'd1);
      checkOutput("zeroCount", 32'(count), 32'd0);
      checkOutput("zeroRunning", 32'(running), 32'd1);
      @(negedge clock);
    end
    checkOutput("zeroDone", 32'(done), 32'd1);
    checkOutput("zeroIdle", 32'(running), 32'd0);
    checkOutput("zeroWrapOff", 32'(wrap), 32'd0);
    checkOutput("zeroPeriodsDone", 32'(periodsDone), 32'd5);

    // Start and stop together in IDLE: no launch.
    period     = 16'd3;
    numPeriods = 16'd1;
    start      = 1'b1;
    stop       = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checkOutput("startStopIdle", 32'(running), 32'd0);
    end
    start = 1'b0;
    stop  = 1'b0;
    @(negedge clock);
    checkOutput("startStopStillIdle", 32'(running), 32'd0);
    checkOutput("startStopPeriodsHold", 32'(periodsDone), 32'd5);

    // Start held high across done re-arms after a single IDLE cycle.
    period     = 16'd2;
    numPeriods = 16'd2;
    start      = 1'b1;
    @(negedge clock);
    checkOutput("holdLaunchIdle", 32'(running), 32'd0);
    @(negedge clock);
    for (int i = 0; i < 6; i++) begin
      checkOutput("holdCount", 32'(count), 32'(i % 3));
      checkOutput("holdRunning", 32'(running), 32'd1);
      @(negedge clock);
    end
    checkOutput("holdDone", 32'(done), 32'd1);
    checkOutput("holdIdleOneCycle", 32'(running), 32'd0);
    checkOutput("holdPeriodsDone", 32'(periodsDone), 32'd2);
    @(negedge clock);
    checkOutput("holdRearmed", 32'(running), 32'd1);
    checkOutput("holdRearmCount", 32'(count), 32'd0);
    checkOutput("holdRearmCleared", 32'(periodsDone), 32'd0);
    checkOutput("holdRearmDoneOff", 32'(done), 32'd0);
    start = 1'b0;
    stop  = 1'b1;
    @(negedge clock);
    stop = 1'b0;
    checkOutput("holdStopped", 32'(running), 32'd0);

    // Comparator window with threshold 40 over a 100-cycle period.
    applyStimulus(16'd99, 16'd1);
    lowCnt  = 0;
    highCnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (count >= 16'd40) highCnt++;
      else lowCnt++;
      @(negedge clock);
    end
    checkOutput("cmpLowCycles", 32'(lowCnt), 32'd40);
    checkOutput("cmpHighCycles", 32'(highCnt), 32'd60);
    checkOutput("cmpDone", 32'(done), 32'd1);

    // Asynchronous reset in the middle of the second period at count 7.
    applyStimulus(16'd9, 16'd0);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (periodsDone == 16'd1 && count == 16'd7) found = 1'b1;
      else @(negedge clock);
    end
    checkOutput("midRstReached", 32'(found), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("midRstCount", 32'(count), 32'd0);
    checkOutput("midRstRunning", 32'(running), 32'd0);
    checkOutput("midRstWrap", 32'(wrap), 32'd0);
    checkOutput("midRstDone", 32'(done), 32'd0);
    checkOutput("midRstPeriodsDone", 32'(periodsDone), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    checkOutput("postRstIdle", 32'(running), 32'd0);

`ifdef PERIOD_COUNTER_EXT_TRIG_EN
    // External trigger: running rises four edges after the first edge that sees it high.
    period     = 16'd9;
    numPeriods = 16'd2;
    #2;
    extTrig = 1'b1;
    repeat (4) @(negedge clock);
    checkOutput("trigNotYet", 32'(running), 32'd0);
    @(negedge clock);
    checkOutput("trigRunning", 32'(running), 32'd1);
    checkOutput("trigCount", 32'(count), 32'd0);
    repeat (3) @(negedge clock);
    extTrig = 1'b0;
    repeat (3) @(negedge clock);
    extTrig = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clock);
      if (done) found = 1'b1;
    end
    checkOutput("trigBurstDone", 32'(found), 32'd1);
    checkOutput("trigPeriodsDone", 32'(periodsDone), 32'd2);
    repeat (2) begin
      @(negedge clock);
      checkOutput("trigRunEdgeIgnored", 32'(running), 32'd0);
    end
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
